// File: rtl/l1cache_nw_wb_if.sv
// Bus bundle of the L1 cache: CPU request/response channel plus the memory request/return channel.
// The cache takes the slave side; the CPU/memory environment takes the master side.
interface l1cache_nw_wb_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output req_ready, resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/l1cache_nw_wb.sv
// Set-associative write-back, write-allocate-without-fill L1 cache, one word per block,
// clock (second-chance) replacement with a per-set pointer and saturating performance counters.
module l1cache_nw_wb #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int NUM_SETS = 128,
    parameter int NUM_WAYS = 8
) (
    input  logic           clk,
    input  logic           rst,
    l1cache_nw_wb_if.slave bus,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count,
    output logic [31:0]    wb_count
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - SET_W - 2;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND} state_t;
    state_t state_q, state_d;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0] refb_q  [NUM_SETS];
    logic [WAY_W-1:0]    ptr_q   [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic [WAY_W-1:0]  way_q;
    logic [WAY_W-1:0]  scan_q;

    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  tag_in;
    logic              unused_addr_lsb;
    assign set_idx         = addr_q[SET_W+1:2];
    assign tag_in          = addr_q[ADDR_W-1:SET_W+2];
    assign unused_addr_lsb = ^addr_q[1:0];

    logic             hit_any, inv_any, victim_found, install, wb_done;
    logic [WAY_W-1:0] hit_way, inv_way, victim_way, inst_way;

    // Parallel tag match across the set; the descending loop leaves the lowest invalid way selected.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim_found = inv_any || !refb_q[set_idx][scan_q];
    assign victim_way   = inv_any ? inv_way : scan_q;
    assign inst_way     = (state_q == VICTIM) ? victim_way : way_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        install           = 1'b0;
        wb_done           = 1'b0;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_rdata    = '0;
        bus.resp_hit      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = LOOKUP;
            end
            LOOKUP: state_d = hit_any ? RESPOND : VICTIM;
            VICTIM: begin
                if (victim_found) begin
                    if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                        state_d = WRITEBACK;
                    end else if (we_q) begin
                        install = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = FILL_REQ;
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = {tag_q[set_idx][way_q], set_idx, 2'b00};
                bus.mem_req_wdata = data_q[set_idx][way_q];
                if (bus.mem_req_ready) begin
                    wb_done = 1'b1;
                    install = we_q;
                    state_d = we_q ? RESPOND : FILL_REQ;
                end
            end
            FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                if (bus.mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.mem_resp_valid) begin
                    install = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_hit   = hit_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs read as their idle values for the whole cycle in which reset is held.
        if (rst) begin
            bus.req_ready     = 1'b0;
            bus.resp_valid    = 1'b0;
            bus.resp_rdata    = '0;
            bus.resp_hit      = 1'b0;
            bus.mem_req_valid = 1'b0;
            bus.mem_req_we    = 1'b0;
            bus.mem_req_addr  = '0;
            bus.mem_req_wdata = '0;
        end
    end

    // Tag/data arrays carry no reset; only the valid/dirty/ref state and pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                refb_q[s]  <= '0;
                ptr_q[s]   <= '0;
            end
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            scan_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q   <= hit_any;
                    rdata_q <= '0;
                    if (hit_any) begin
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
                        refb_q[set_idx][hit_way] <= 1'b1;
                        if (we_q) begin
                            data_q[set_idx][hit_way]  <= wdata_q;
                            dirty_q[set_idx][hit_way] <= 1'b1;
                        end else begin
                            rdata_q <= data_q[set_idx][hit_way];
                        end
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        scan_q <= ptr_q[set_idx];
                    end
                end
                VICTIM: begin
                    if (victim_found) begin
                        way_q <= victim_way;
                    end else begin
                        refb_q[set_idx][scan_q] <= 1'b0;
                        scan_q <= scan_q + WAY_W'(1);
                    end
                end
                FILL_WAIT: if (bus.mem_resp_valid) rdata_q <= bus.mem_resp_rdata;
                default: ;
            endcase
            if (wb_done && wb_count != '1) wb_count <= wb_count + 32'd1;
            if (install) begin
                valid_q[set_idx][inst_way] <= 1'b1;
                dirty_q[set_idx][inst_way] <= we_q;
                refb_q[set_idx][inst_way]  <= 1'b1;
                tag_q[set_idx][inst_way]   <= tag_in;
                data_q[set_idx][inst_way]  <= we_q ? wdata_q : bus.mem_resp_rdata;
                ptr_q[set_idx]             <= inst_way + WAY_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_l1cache_nw_wb.sv
// Self-checking bench for l1cache_nw_wb: directed scenarios plus random traffic checked against a
// behavioural cache/memory model (golden memory image plus clock replacement over per-set way tables).
module tb_l1cache_nw_wb;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 32;
    localparam int NUM_SETS = 128;
    localparam int NUM_WAYS = 8;
    localparam int SET_BITS = $clog2(NUM_SETS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_count, miss_count, wb_count;
    int          checks = 0;
    int          failures = 0;

    l1cache_nw_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    l1cache_nw_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Backing memory as seen by the DUT, and the value the CPU should observe at each word.
    logic [31:0] mem    [int];
    logic [31:0] golden [int];

    bit          m_valid [NUM_SETS][NUM_WAYS];
    bit          m_dirty [NUM_SETS][NUM_WAYS];
    bit          m_ref   [NUM_SETS][NUM_WAYS];
    int          m_tag   [NUM_SETS][NUM_WAYS];
    int          m_ptr   [NUM_SETS];
    int          m_hits, m_misses, m_wbs;

    logic        obs_resp, obs_hit;
    logic [31:0] obs_rdata, obs_wr_data;
    int          obs_latency, obs_nrd, obs_nwr, obs_wr_addr, obs_rd_addr, obs_req_cycles, obs_unstable;

    function automatic logic [31:0] init_val(int a);
        return 32'hC0DE0000 ^ 32'(a);
    endfunction

    function automatic logic [31:0] mem_rd(int a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] gold_rd(int a);
        return golden.exists(a) ? golden[a] : init_val(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_ref[s][w]   = 0;
                m_tag[s][w]   = 0;
            end
        end
        m_hits = 0;
        m_misses = 0;
        m_wbs = 0;
        golden.delete();
        foreach (mem[a]) golden[a] = mem[a];
    endtask

    task automatic model_access(input logic we, input int addr, input logic [31:0] wdata,
                                output logic exp_hit, output logic exp_wb, output int exp_wb_addr,
                                output logic [31:0] exp_wb_data, output logic [31:0] exp_rdata);
        int set  = (addr >> 2) % NUM_SETS;
        int tag  = addr >> (2 + SET_BITS);
        int word = addr & ~3;
        int way  = -1;
        exp_wb = 0;
        exp_wb_addr = 0;
        exp_wb_data = 0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
        if (way >= 0) begin
            exp_hit = 1;
            m_hits++;
            m_ref[set][way] = 1;
            if (we) m_dirty[set][way] = 1;
        end else begin
            exp_hit = 0;
            m_misses++;
            for (int w = NUM_WAYS - 1; w >= 0; w--)
                if (!m_valid[set][w]) way = w;
            if (way < 0) begin
                while (m_ref[set][m_ptr[set]]) begin
                    m_ref[set][m_ptr[set]] = 0;
                    m_ptr[set] = (m_ptr[set] + 1) % NUM_WAYS;
                end
                way = m_ptr[set];
            end
            if (m_valid[set][way] && m_dirty[set][way]) begin
                exp_wb      = 1;
                exp_wb_addr = (m_tag[set][way] << (2 + SET_BITS)) | (set << 2);
                exp_wb_data = gold_rd(exp_wb_addr);
                m_wbs++;
            end
            m_valid[set][way] = 1;
            m_dirty[set][way] = we;
            m_ref[set][way]   = 1;
            m_tag[set][way]   = tag;
            m_ptr[set]        = (way + 1) % NUM_WAYS;
        end
        exp_rdata = we ? 32'h0 : gold_rd(word);
        if (we) golden[word] = wdata;
    endtask

    // Issues one CPU request (called at a negedge with the DUT idle) and plays the memory side until the response.
    task automatic applyStimulus(input logic we, input int addr, input logic [31:0] wdata, input int stall);
        int          stall_left = stall;
        int          resp_delay = 0;
        logic        rd_pending = 0;
        logic        seen_req = 0;
        logic [19:0] first_addr = '0;
        obs_resp = 0; obs_hit = 0; obs_rdata = 0; obs_latency = 0;
        obs_nrd = 0; obs_nwr = 0; obs_wr_addr = 0; obs_wr_data = 0;
        obs_rd_addr = 0; obs_req_cycles = 0; obs_unstable = 0;
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = 20'(addr);
        bus.req_wdata = wdata;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !obs_resp; cyc++) begin
            @(negedge clk);
            bus.req_valid      = 1'b0;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (bus.resp_valid) begin
                obs_resp    = 1;
                obs_rdata   = bus.resp_rdata;
                obs_hit     = bus.resp_hit;
                obs_latency = cyc;
            end
            if (bus.mem_req_valid) begin
                obs_req_cycles++;
                if (!seen_req) begin
                    first_addr = bus.mem_req_addr;
                    seen_req   = 1;
                end else if (bus.mem_req_addr != first_addr) begin
                    obs_unstable++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    seen_req = 0;
                    if (bus.mem_req_we) begin
                        obs_nwr++;
                        obs_wr_addr = int'(bus.mem_req_addr);
                        obs_wr_data = bus.mem_req_wdata;
                        mem[obs_wr_addr] = bus.mem_req_wdata;
                    end else begin
                        obs_nrd++;
                        obs_rd_addr = int'(bus.mem_req_addr);
                        rd_pending  = 1;
                        resp_delay  = $urandom_range(0, 3);
                    end
                end
            end else if (rd_pending) begin
                if (resp_delay == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = mem_rd(obs_rd_addr);
                    rd_pending = 0;
                end else begin
                    resp_delay--;
                end
            end
        end
        if (!obs_resp) checkOutput("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic doAccess(input logic we, input int addr, input logic [31:0] wdata, input int stall, input string tg);
        logic        exp_hit, exp_wb;
        int          exp_wb_addr;
        logic [31:0] exp_wb_data, exp_rdata;
        model_access(we, addr, wdata, exp_hit, exp_wb, exp_wb_addr, exp_wb_data, exp_rdata);
        applyStimulus(we, addr, wdata, stall);
        checkOutput({tg, "_hit"}, 32'(obs_hit), 32'(exp_hit));
        checkOutput({tg, "_rdata"}, obs_rdata, exp_rdata);
        if (exp_hit) checkOutput({tg, "_hit_latency"}, 32'(obs_latency), 32'd2);
        checkOutput({tg, "_mem_writes"}, 32'(obs_nwr), 32'(exp_wb));
        if (exp_wb) begin
            checkOutput({tg, "_wb_addr"}, 32'(obs_wr_addr), 32'(exp_wb_addr));
            checkOutput({tg, "_wb_data"}, obs_wr_data, exp_wb_data);
        end
        checkOutput({tg, "_mem_reads"}, 32'(obs_nrd), 32'(!exp_hit && !we));
        if (!exp_hit && !we) checkOutput({tg, "_fill_addr"}, 32'(obs_rd_addr), 32'(addr & ~3));
        checkOutput({tg, "_hit_count"}, hit_count, 32'(m_hits));
        checkOutput({tg, "_miss_count"}, miss_count, 32'(m_misses));
        checkOutput({tg, "_wb_count"}, wb_count, 32'(m_wbs));
    endtask

    task automatic check_reset_outputs(input string tg);
        checkOutput({tg, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tg, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tg, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        checkOutput({tg, "_resp_hit"}, 32'(bus.resp_hit), 32'd0);
        checkOutput({tg, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        checkOutput({tg, "_mem_req_we"}, 32'(bus.mem_req_we), 32'd0);
        checkOutput({tg, "_mem_req_addr"}, 32'(bus.mem_req_addr), 32'd0);
        checkOutput({tg, "_mem_req_wdata"}, bus.mem_req_wdata, 32'd0);
        checkOutput({tg, "_counters"}, hit_count | miss_count | wb_count, 32'd0);
    endtask

    task automatic do_reset(input string tg);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(tg);
        rst = 1'b0;
        @(negedge clk);
        checkOutput({tg, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        model_reset();
    endtask

    initial begin
        logic [31:0] h0, m0, w0;
        int          sets [3] = '{0, 1, 5};
        bit          got_fill;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = '0;
        mem[32'h10]  = 32'hDEADBEEF;
        do_reset("reset0");

        doAccess(0, 32'h00010, 32'h0, 0, "s1_fill");
        checkOutput("s1_fill_addr_const", 32'(obs_rd_addr), 32'h00010);
        checkOutput("s1_fill_data_const", obs_rdata, 32'hDEADBEEF);
        doAccess(0, 32'h00010, 32'h0, 0, "s1_reread");
        checkOutput("s1_hit_const", 32'(obs_hit), 32'd1);
        checkOutput("s1_hit_count", hit_count, 32'd1);
        checkOutput("s1_miss_count", miss_count, 32'd1);

        doAccess(1, 32'h00200, 32'h12345678, 0, "s2_wmiss");
        checkOutput("s2_no_mem", 32'(obs_nrd + obs_nwr), 32'd0);
        doAccess(0, 32'h00200, 32'h0, 0, "s2_read");
        checkOutput("s2_read_const", obs_rdata, 32'h12345678);

        h0 = hit_count; m0 = miss_count; w0 = wb_count;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = $urandom;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        checkOutput("stray_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("stray_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("stray_mem_req", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("stray_counters", hit_count + miss_count + wb_count, h0 + m0 + w0);
        doAccess(0, 32'h00010, 32'h0, 0, "stray_reread");

        doAccess(0, 32'h030C4, 32'h0, 5, "stall");
        checkOutput("stall_valid_cycles", 32'(obs_req_cycles), 32'd6);
        checkOutput("stall_addr_stable", 32'(obs_unstable), 32'd0);
        checkOutput("stall_single_req", 32'(obs_nrd), 32'd1);

        do_reset("reset1");
        for (int i = 0; i < NUM_WAYS; i++)
            doAccess(1, i * 32'h200, 32'hA0000000 + 32'(i), 0, "s3_fill");
        doAccess(1, 32'h01000, 32'hBBBB0000, 0, "s3_evict");
        checkOutput("s3_wb_addr_const", 32'(obs_wr_addr), 32'h00000);
        checkOutput("s3_wb_data_const", obs_wr_data, 32'hA0000000);
        checkOutput("s3_wb_count", wb_count, 32'd1);
        doAccess(0, 32'h00000, 32'h0, 0, "s3_reload");
        checkOutput("s3_reload_const", obs_rdata, 32'hA0000000);

        for (int n = 0; n < 300; n++) begin
            int a = (int'($urandom_range(0, 11)) << 9) | (sets[$urandom_range(0, 2)] << 2) | int'($urandom_range(0, 3));
            doAccess(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), "rand");
        end

        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 20'h7FFF0;
        @(posedge clk);
        got_fill = 0;
        for (int cyc = 0; cyc < 30 && !got_fill; cyc++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                bus.mem_req_ready = 1'b1;
                if (bus.mem_req_we) mem[int'(bus.mem_req_addr)] = bus.mem_req_wdata;
                else got_fill = 1;
            end
        end
        checkOutput("rstfw_fill_seen", 32'(got_fill), 32'd1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        do_reset("rstfw");
        doAccess(0, 32'h7FFF0, 32'h0, 0, "rstfw_reread");
        checkOutput("rstfw_miss_const", 32'(obs_hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1cache_nw_wb.md
L1CACHE_NW_WB -- requirements
Module: l1cache_nw_wb

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: byte address width.
REQ-002 SHALL have parameter DATA_W, default 32: word width; one word per block.
REQ-003 SHALL have parameter NUM_SETS, default 128: set count, power of two.
REQ-004 SHALL have parameter NUM_WAYS, default 8: ways per set, power of two, 2..16.
REQ-005 SHALL derive SET_W = log2(NUM_SETS) and TAG_W = ADDR_W - SET_W - 2; set = addr[SET_W+1:2], tag = addr[ADDR_W-1:SET_W+2].
REQ-006 SHALL have clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have req_valid, input, 1 / req_ready, output, 1: CPU request handshake.
REQ-009 SHALL have req_we, input, 1 / req_addr, input, ADDR_W / req_wdata, input, DATA_W: request fields.
REQ-010 SHALL have resp_valid, output, 1 / resp_rdata, output, DATA_W / resp_hit, output, 1: one-cycle response pulse, read data and hit flag.
REQ-011 SHALL have mem_req_valid, output, 1 / mem_req_ready, input, 1: memory request handshake.
REQ-012 SHALL have mem_req_we, output, 1 / mem_req_addr, output, ADDR_W / mem_req_wdata, output, DATA_W: memory request fields.
REQ-013 SHALL have mem_resp_valid, input, 1 / mem_resp_rdata, input, DATA_W: memory read return.
REQ-014 SHALL have hit_count, miss_count, wb_count, output, 32 each: saturating performance counters.

Function
REQ-015 SHALL implement FSM states IDLE, LOOKUP, VICTIM, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, and all fields are registered; state goes to LOOKUP.
REQ-017 LOOKUP SHALL compare the tag against all ways of the set in one cycle; hit = valid and tag match.
REQ-018 On a read hit, resp_valid SHALL pulse high with resp_hit=1 and the stored data in the cycle after LOOKUP (2 cycles after acceptance); state returns to IDLE.
REQ-019 On a write hit, the block SHALL be written and marked dirty; resp_valid pulses with resp_hit=1 and resp_rdata=0 at the same latency.
REQ-020 Every hit SHALL set the way's reference bit.
REQ-021 On a miss, VICTIM SHALL choose the lowest-indexed invalid way in a single cycle if any exists.
REQ-022 If no way is invalid, VICTIM SHALL scan clock-style from the set pointer, one way per cycle: ref=1 -> clear it and advance (mod NUM_WAYS); ref=0 -> select that way. The scan is bounded by NUM_WAYS+1 cycles.
REQ-023 If the victim is valid and dirty, WRITEBACK SHALL issue mem_req_we=1, mem_req_addr={victim tag, set, 2'b00}, mem_req_wdata=victim data, and increment wb_count.
REQ-024 A write miss SHALL skip the fill: the block is installed dirty with req_wdata; resp_valid pulses with resp_hit=0.
REQ-025 A read miss SHALL issue mem_req_we=0 with a word-aligned address, wait in FILL_WAIT for mem_resp_valid, and install the block clean. resp_valid then pulses with resp_hit=0 and resp_rdata=mem_resp_rdata in the cycle after mem_resp_valid.
REQ-026 On install, the way SHALL be marked valid, its ref bit set to 1, and the set pointer set to (victim+1) mod NUM_WAYS.
REQ-027 mem_req_valid SHALL stay high, with all fields stable, until the cycle in which mem_req_ready is high; it then drops the next cycle. Writes get no response.
REQ-028 mem_resp_valid SHALL be ignored outside FILL_WAIT.
REQ-029 hit_count or miss_count SHALL increment once per request in LOOKUP; all counters saturate at 0xFFFFFFFF.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL:
- go to IDLE;
- clear all valid, dirty and ref bits, all set pointers and all counters;
- drive req_ready=0, resp_valid=0, resp_rdata=0, resp_hit=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
REQ-031 Reset during any state, including WRITEBACK or FILL_WAIT, SHALL abandon the operation without writeback; dirty data is lost. req_ready returns to 1 in the first cycle after rst deasserts.

Verification
REQ-032 Bench SHALL cover these directed scenarios (default parameters):
- read 0x00010 after reset -> mem read addr 0x00010; return 0xDEADBEEF -> resp_rdata 0xDEADBEEF, resp_hit 0. Reread -> resp_hit 1 after 2 cycles, no mem request, hit_count 1, miss_count 1.
- write 0x00200 data 0x12345678 (miss) -> no mem request, resp_hit 0; read 0x00200 -> hit, 0x12345678.
- writes to 0x00000, 0x00200, ..., 0x00E00 (set 0, all 8 ways), then write 0x01000 -> scan clears all refs, victim way 0, mem write addr 0x00000 with way-0 data, wb_count 1.
- hold mem_req_ready low 5 cycles during a fill -> mem_req_valid high with constant addr all 5 cycles; single request after ready.
- assert rst in FILL_WAIT -> all outputs at reset values next cycle; a later read of the same address misses.
- stray mem_resp_valid in IDLE -> no state or output change.
